// File: rtl/simple_counter_driver_checker.sv
// Burst stimulus engine for simple_counter_module plus a cycle-accurate reference model
// that checks count_value_i / overflow_i every cycle and keeps error statistics.
module simple_counter_driver_checker #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  // start_i is a single-cycle request honoured only while busy_o=0; done_o is a
  // single-cycle completion pulse; requests seen while busy_o=1 are dropped.
  input  logic             start_i,
  input  logic [CNT_W-1:0] on_cycles_i,
  input  logic [CNT_W-1:0] off_cycles_i,
  input  logic [7:0]       bursts_i,
  output logic             enable_o,
  input  logic [WIDTH-1:0] count_value_i,
  input  logic             overflow_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [CNT_W-1:0] mismatch_cnt_o,
  output logic [CNT_W-1:0] overflow_cnt_o,
  output logic [WIDTH-1:0] first_err_val_o,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ON    = 3'd1,
    S_OFF   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WIDTH-1:0] W_ZERO  = '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] on_q, on_d;
  logic [CNT_W-1:0] off_q, off_d;
  logic [7:0]       bursts_q, bursts_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             enable_q, enable_d;
  logic             done_q, done_d;
  logic             accept;

  logic [WIDTH-1:0] exp_cnt_q, exp_cnt_d;
  logic             exp_ovf_q, exp_ovf_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
  logic [CNT_W-1:0] overflow_cnt_q, overflow_cnt_d;
  logic [WIDTH-1:0] first_err_q, first_err_d;

  logic             mismatch;
  logic             err_base;
  logic [CNT_W-1:0] mis_base;
  logic [CNT_W-1:0] ovf_base;
  logic [WIDTH-1:0] ferr_base;

  always_comb begin
    state_d  = state_q;
    on_d     = on_q;
    off_d    = off_q;
    bursts_d = bursts_q;
    cyc_d    = cyc_q;
    accept   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          accept   = 1'b1;
          on_d     = on_cycles_i;
          off_d    = off_cycles_i;
          bursts_d = bursts_i;
          cyc_d    = '0;
          if (bursts_i == 8'd0)         state_d = S_DONE;
          else if (on_cycles_i != '0)   state_d = S_ON;
          else                          state_d = S_OFF;
        end
      end
      S_ON: begin
        if (cyc_q == on_q - CNT_ONE) begin
          cyc_d = '0;
          if (bursts_q == 8'd1 && off_q == '0) begin
            bursts_d = 8'd0;
            state_d  = S_DRAIN;
          end else begin
            state_d = S_OFF;
          end
        end else begin
          cyc_d = cyc_q + CNT_ONE;
        end
      end
      S_OFF: begin
        // An off length of zero still occupies one cycle here.
        if (off_q == '0 || cyc_q == off_q - CNT_ONE) begin
          cyc_d    = '0;
          bursts_d = bursts_q - 8'd1;
          if (bursts_q > 8'd1) state_d = (on_q != '0) ? S_ON : S_OFF;
          else                 state_d = S_DRAIN;
        end else begin
          cyc_d = cyc_q + CNT_ONE;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    enable_d = (state_d == S_ON);
    done_d   = (state_d == S_DONE);
  end

  // Reference model runs in every state so it tracks the counter with zero offset.
  always_comb begin
    exp_cnt_d = exp_cnt_q + {{(WIDTH-1){1'b0}}, enable_q};
    exp_ovf_d = enable_q && (exp_cnt_q == {WIDTH{1'b1}});
  end

  always_comb begin
    mismatch  = (count_value_i != exp_cnt_q) || (overflow_i != exp_ovf_q);
    err_base  = accept ? 1'b0   : error_q;
    mis_base  = accept ? '0     : mismatch_cnt_q;
    ovf_base  = accept ? '0     : overflow_cnt_q;
    ferr_base = accept ? W_ZERO : first_err_q;

    error_d        = err_base;
    mismatch_cnt_d = mis_base;
    first_err_d    = ferr_base;
    overflow_cnt_d = ovf_base;
    if (mismatch) begin
      error_d = 1'b1;
      if (mis_base != {CNT_W{1'b1}}) mismatch_cnt_d = mis_base + CNT_ONE;
      if (!err_base) first_err_d = count_value_i;
    end
    if (overflow_i && ovf_base != {CNT_W{1'b1}}) overflow_cnt_d = ovf_base + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      on_q           <= '0;
      off_q          <= '0;
      bursts_q       <= '0;
      cyc_q          <= '0;
      enable_q       <= 1'b0;
      done_q         <= 1'b0;
      exp_cnt_q      <= '0;
      exp_ovf_q      <= 1'b0;
      error_q        <= 1'b0;
      mismatch_cnt_q <= '0;
      overflow_cnt_q <= '0;
      first_err_q    <= '0;
    end else begin
      state_q        <= state_d;
      on_q           <= on_d;
      off_q          <= off_d;
      bursts_q       <= bursts_d;
      cyc_q          <= cyc_d;
      enable_q       <= enable_d;
      done_q         <= done_d;
      exp_cnt_q      <= exp_cnt_d;
      exp_ovf_q      <= exp_ovf_d;
      error_q        <= error_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      overflow_cnt_q <= overflow_cnt_d;
      first_err_q    <= first_err_d;
    end
  end

  assign enable_o        = enable_q;
  assign busy_o          = (state_q != S_IDLE);
  assign done_o          = done_q;
  assign error_o         = error_q;
  assign mismatch_cnt_o  = mismatch_cnt_q;
  assign overflow_cnt_o  = overflow_cnt_q;
  assign first_err_val_o = first_err_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_simple_counter_driver_checker.sv
// Bench for simple_counter_driver_checker: a behavioural counter closes the loop and
// table-driven burst vectors plus directed corner sequences check the outputs.
module tb_simple_counter_driver_checker;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [15:0] on_i;
  logic [15:0] off_i;
  logic [7:0]  bursts_i;
  logic        enable_o;
  logic [7:0]  count_value;
  logic        overflow;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [15:0] mismatch_cnt_o;
  logic [15:0] overflow_cnt_o;
  logic [7:0]  first_err_val_o;
  logic [2:0]  state_o;

  logic [7:0]  cnt_q;
  logic        ovf_q;
  logic [7:0]  inj;

  int checks = 0;
  int errors = 0;

  simple_counter_driver_checker #(.WIDTH(8), .CNT_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .start_i         (start_i),
    .on_cycles_i     (on_i),
    .off_cycles_i    (off_i),
    .bursts_i        (bursts_i),
    .enable_o        (enable_o),
    .count_value_i   (count_value),
    .overflow_i      (overflow),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .error_o         (error_o),
    .mismatch_cnt_o  (mismatch_cnt_o),
    .overflow_cnt_o  (overflow_cnt_o),
    .first_err_val_o (first_err_val_o),
    .state_o         (state_o)
  );

  // Clock and the behavioural counter that the driver controls.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + {7'd0, enable_o};
      ovf_q <= enable_o && (cnt_q == 8'hFF);
    end
  end

  assign count_value = cnt_q + inj;
  assign overflow    = ovf_q;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a sequence and measures it up to and including the done_o cycle.
  task automatic run_seq(input logic [15:0] on, input logic [15:0] off, input logic [7:0] b,
                         input int extra_at, output int len, output int en_cnt,
                         output int rises, output int first_en);
    logic prev_en;
    bit   got_done;
    len = 0; en_cnt = 0; rises = 0; first_en = 0; prev_en = 1'b0; got_done = 0;
    on_i = on; off_i = off; bursts_i = b; start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int c = 1; c <= 2000 && !got_done; c++) begin
      if (c == extra_at) begin
        start_i = 1'b1; on_i = 16'd3; off_i = 16'd1; bursts_i = 8'd9;
      end else begin
        start_i = 1'b0;
      end
      if (busy_o) len++;
      if (enable_o) begin
        en_cnt++;
        if (first_en == 0) first_en = c;
        if (!prev_en) rises++;
      end
      prev_en = enable_o;
      if (done_o) got_done = 1;
      else step();
    end
    start_i = 1'b0;
    check("done_seen", longint'(got_done), 1);
    step();
    check("busy_after_done", busy_o, 0);
    check("done_single_pulse", done_o, 0);
  endtask

  typedef struct {
    logic [15:0] on;
    logic [15:0] off;
    logic [7:0]  bursts;
    int          exp_len;
    int          exp_en;
    int          exp_rises;
    int          exp_first;
    logic [7:0]  exp_cnt;
    logic [15:0] exp_ovf;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int len, en_cnt, rises, first_en;
    logic [7:0] forced;
    bit got_done;

    rst = 1'b1; start_i = 1'b0; on_i = '0; off_i = '0; bursts_i = '0; inj = 8'd0;
    // {on, off, bursts, busy cycles, enable cycles, enable bursts, first enable, count, overflows}
    vecs[0] = '{16'd20,  16'd5, 8'd1,  27,  20, 1, 1, 8'd20, 16'd0};
    vecs[1] = '{16'd250, 16'd0, 8'd1, 252, 250, 1, 1, 8'd14, 16'd1};
    vecs[2] = '{16'd3,   16'd2, 8'd4,  22,  12, 4, 1, 8'd26, 16'd0};
    vecs[3] = '{16'd5,   16'd5, 8'd0,   1,   0, 0, 0, 8'd26, 16'd0};
    vecs[4] = '{16'd0,   16'd0, 8'd2,   4,   0, 0, 0, 8'd26, 16'd0};
    vecs[5] = '{16'd0,   16'd3, 8'd2,   8,   0, 0, 0, 8'd26, 16'd0};
    vecs[6] = '{16'd2,   16'd0, 8'd3,  10,   6, 3, 1, 8'd32, 16'd0};

    step(); step();
    rst = 1'b0;
    check("rst_enable", enable_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_error", error_o, 0);
    check("rst_mismatch_cnt", mismatch_cnt_o, 0);
    check("rst_overflow_cnt", overflow_cnt_o, 0);
    check("rst_first_err", first_err_val_o, 0);
    check("rst_state", state_o, 0);
    step();

    foreach (vecs[i]) begin
      run_seq(vecs[i].on, vecs[i].off, vecs[i].bursts, -1, len, en_cnt, rises, first_en);
      check($sformatf("vec%0d_len", i), len, vecs[i].exp_len);
      check($sformatf("vec%0d_enable_cycles", i), en_cnt, vecs[i].exp_en);
      check($sformatf("vec%0d_enable_bursts", i), rises, vecs[i].exp_rises);
      check($sformatf("vec%0d_first_enable", i), first_en, vecs[i].exp_first);
      check($sformatf("vec%0d_count", i), count_value, vecs[i].exp_cnt);
      check($sformatf("vec%0d_overflow_cnt", i), overflow_cnt_o, vecs[i].exp_ovf);
      check($sformatf("vec%0d_error", i), error_o, 0);
    end

    // start_i pulsed while busy must not alter the running sequence.
    run_seq(16'd30, 16'd0, 8'd1, 5, len, en_cnt, rises, first_en);
    check("busy_start_len", len, 32);
    check("busy_start_enable_cycles", en_cnt, 30);
    check("busy_start_count", count_value, 62);
    check("busy_start_error", error_o, 0);

    // Corrupt the counter view for three cycles mid-burst.
    on_i = 16'd10; off_i = 16'd2; bursts_i = 8'd1; start_i = 1'b1;
    step();
    start_i = 1'b0;
    step(); step(); step();
    forced = cnt_q + 8'd1;
    inj = 8'd1;
    step();
    check("inj_error_set", error_o, 1);
    step(); step();
    inj = 8'd0;
    got_done = 0;
    for (int c = 0; c < 100 && !got_done; c++) begin
      if (done_o) got_done = 1;
      else step();
    end
    check("inj_done_seen", longint'(got_done), 1);
    check("inj_error_sticky", error_o, 1);
    check("inj_mismatch_cnt", mismatch_cnt_o, 3);
    check("inj_first_err_val", first_err_val_o, forced);
    step();

    // bursts=0 restart clears the error statistics and finishes at once.
    on_i = 16'd7; off_i = 16'd7; bursts_i = 8'd0; start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("clr_error", error_o, 0);
    check("clr_mismatch_cnt", mismatch_cnt_o, 0);
    check("clr_first_err", first_err_val_o, 0);
    check("zero_bursts_done", done_o, 1);
    check("zero_bursts_enable", enable_o, 0);
    step();
    check("zero_bursts_idle", busy_o, 0);
    check("zero_bursts_count", count_value, 72);

    // Reset in the middle of an ON phase.
    on_i = 16'd40; off_i = 16'd3; bursts_i = 8'd2; start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (10) step();
    check("mid_on_enable", enable_o, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_enable", enable_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_state", state_o, 0);
    check("midrst_error", error_o, 0);
    repeat (5) step();
    check("midrst_no_mismatch", mismatch_cnt_o, 0);

    run_seq(16'd4, 16'd1, 8'd1, -1, len, en_cnt, rises, first_en);
    check("post_rst_len", len, 7);
    check("post_rst_count", count_value, 4);
    check("post_rst_error", error_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
